// File: rtl/isolation_pkg.sv
// Shared types and helpers for the isolation stream ports (FIFO reader and writer sides).
package isolation_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PKT       = 2'd1,
    DECOUPLED = 2'd2
  } rd_state_t;

  // FIFO entries carry the tlast flag in the bit just above the data.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer_2.sv
// Two-slot registered output stage: head drives the stream, skid absorbs one
// extra entry so the upstream read decision never waits on ready.
module axis_skid_buffer_2 #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             pop,
  output logic [1:0]       buf_cnt
);

  logic [1:0]       cnt_p0;
  logic [WIDTH-1:0] head_p0;
  logic [WIDTH-1:0] skid_p1;
  logic             accept;

  assign valid   = (cnt_p0 != 2'd0);
  assign pop     = valid && ready;
  assign accept  = push && (cnt_p0 != 2'd2);
  assign head    = head_p0;
  assign buf_cnt = cnt_p0;

  // occupancy: control only, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt_p0 <= cnt_p0 + 2'd1;
        2'b01:   cnt_p0 <= cnt_p0 - 2'd1;
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // slot data: an incoming entry lands in head whenever head is (or becomes) free
  always_ff @(posedge clk) begin
    if (accept && ((cnt_p0 == 2'd0) || ((cnt_p0 == 2'd1) && pop))) begin
      head_p0 <= push_data;
    end else if (pop && (cnt_p0 == 2'd2)) begin
      head_p0 <= skid_p1;
    end
    if (accept && (cnt_p0 == 2'd1) && !pop) begin
      skid_p1 <= push_data;
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains {last,data} entries from an FWFT FIFO onto an AXI-Stream master, with
// packet-boundary-safe decoupling and a count of completed packets.
module fifo_axis_reader
  import isolation_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  decouple,
  output logic                  decouple_done,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH);

  rd_state_t          state;
  rd_state_t          state_next;
  logic               read_gate;
  logic               rd_en;
  logic               pop;
  logic [1:0]         buf_cnt;
  logic [ENTRY_W-1:0] head;

  // Mid-packet reads ignore decouple so a packet is never cut short.
  always_comb begin
    read_gate = 1'b0;
    case (state)
      IDLE:    read_gate = !decouple;
      PKT:     read_gate = 1'b1;
      default: read_gate = 1'b0;
    endcase
  end

  assign rd_en      = !rst && !fifo_empty && (buf_cnt != 2'd2) && read_gate;
  assign fifo_rd_en = rd_en;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (decouple) begin
          state_next = DECOUPLED;
        end else if (rd_en && !fifo_dout[DATA_WIDTH]) begin
          state_next = PKT;
        end
      end
      PKT: begin
        if (rd_en && fifo_dout[DATA_WIDTH]) begin
          state_next = decouple ? DECOUPLED : IDLE;
        end
      end
      DECOUPLED: begin
        if (!decouple) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  axis_skid_buffer_2 #(
    .WIDTH(ENTRY_W)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_en),
    .push_data(fifo_dout),
    .ready    (m_axis_tready),
    .valid    (m_axis_tvalid),
    .head     (head),
    .pop      (pop),
    .buf_cnt  (buf_cnt)
  );

  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = head[DATA_WIDTH];
  assign decouple_done = (state == DECOUPLED) && (buf_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (pop && m_axis_tlast) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: an FWFT FIFO model feeds the DUT and a stream
// scoreboard expects every pushed entry back in order with a matching packet count.
module tb_fifo_axis_reader;

  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int EW   = DW + 1;
  localparam int MEMD = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          decouple = 1'b0;
  logic          decouple_done;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  fifo_axis_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .decouple     (decouple),
    .decouple_done(decouple_done),
    .pkt_count    (pkt_count)
  );

  // FWFT FIFO model: head always visible, advance on rd_en, flushed with the DUT reset
  logic [EW-1:0] mem [0:MEMD-1];
  logic [31:0]   wp = 32'd0;
  logic [31:0]   rp = 32'd0;
  logic          flush = 1'b0;

  assign fifo_empty = (wp == rp);
  assign fifo_dout  = mem[rp[11:0]];

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_rd_en && !fifo_empty) rp <= rp + 32'd1;
  end

  // reference: every pushed entry must come out once, in order; count tlast handshakes mod 2^CW
  logic [EW-1:0] exp_q [$];
  int            mcnt = 0;
  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [EW-1:0] prev_beat;

  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (pkt_count !== CW'(mcnt)) begin
        fails++;
        $display("FAIL pkt_count_track: got %0d want %0d", pkt_count, CW'(mcnt));
      end
      if (rst) begin
        exp_q.delete();
        mcnt = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_beat) begin
            fails++;
            $display("FAIL axis_hold: got v=%0b %0h want v=1 %0h", m_axis_tvalid,
                     {m_axis_tlast, m_axis_tdata}, prev_beat);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL stream_extra: got %0h want no beat", {m_axis_tlast, m_axis_tdata});
          end else begin
            if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin
              fails++;
              $display("FAIL stream_order: got %0h want %0h", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
          if (m_axis_tlast) mcnt = (mcnt + 1) % (1 << CW);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic last, input logic [DW-1:0] d);
    mem[wp[11:0]] = {last, d};
    wp = wp + 32'd1;
    exp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b1;
    m_axis_tready = 1'b0;
    decouple = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    push_beat(1'b1, 32'h1234);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL rd_en_in_reset: got %0b want 0", fifo_rd_en);
    end
    do_reset();
    exp_q.delete();
    mon_en = 1'b1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || decouple_done !== 1'b0 || pkt_count !== '0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b dd=%0b cnt=%0d rd=%0b want 0 0 0 0",
               m_axis_tvalid, decouple_done, pkt_count, fifo_rd_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    m_axis_tready = 1'b1;
    push_beat(1'b1, 32'hA5);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1) begin
      fails++; $display("FAIL single_rd_en: got %0b want 1", fifo_rd_en);
    end
    tick();
    tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA5 || m_axis_tlast !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL single_beat: got v=%0b d=%0h l=%0b rd=%0b want 1 a5 1 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_rd_en);
    end
    tick();
    tests++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL single_count: got v=%0b cnt=%0d want 0 1", m_axis_tvalid, pkt_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [0:7];
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      push_beat(i == 7, d[i]);
    end
    #1;
    tests++;
    if (fifo_rd_en !== 1'b1) begin
      fails++; $display("FAIL b2b_rd_en: got %0b want 1", fifo_rd_en);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[i] || m_axis_tlast !== (i == 7)) begin
        fails++;
        $display("FAIL b2b_beat%0d: got v=%0b d=%0h l=%0b want 1 %0h %0b", i,
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, d[i], (i == 7));
      end
    end
    tick();
    tests++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL b2b_end: got v=%0b cnt=%0d want 0 1", m_axis_tvalid, pkt_count);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [0:4];
    int got;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d[i] = $urandom;
      push_beat(i == 4, d[i]);
    end
    repeat (4) tick();
    tests++;
    if (fifo_rd_en !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[0] || (wp - rp) !== 32'd3) begin
      fails++;
      $display("FAIL bp_stall: got rd=%0b v=%0b d=%0h fifo=%0d want 0 1 %0h 3",
               fifo_rd_en, m_axis_tvalid, m_axis_tdata, wp - rp, d[0]);
    end
    m_axis_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (m_axis_tvalid) begin
        tests++;
        if (m_axis_tdata !== d[got]) begin
          fails++; $display("FAIL bp_order%0d: got %0h want %0h", got, m_axis_tdata, d[got]);
        end
        got++;
      end
      tick();
    end
    tests++;
    if (got != 5 || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL bp_total: got beats=%0d cnt=%0d want 5 1", got, pkt_count);
    end
  endtask

  task automatic test_decouple_mid();
    int seen, last_hs, done_cyc, got;
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) push_beat(i == 5, $urandom);
    for (int i = 0; i < 3; i++) push_beat(i == 2, $urandom);
    seen = 0; last_hs = -1; done_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) decouple = 1'b1;
      #0;
      if (decouple_done) begin
        done_cyc = c;
        break;
      end
      if (m_axis_tvalid) begin
        seen++;
        last_hs = c;
      end
      tick();
    end
    tests++;
    if (seen != 6 || done_cyc != last_hs + 1 || m_axis_tvalid !== 1'b0 || (wp - rp) !== 32'd3) begin
      fails++;
      $display("FAIL dec_mid_stop: got beats=%0d done@%0d lasths@%0d v=%0b fifo=%0d want 6 lasths+1 0 3",
               seen, done_cyc, last_hs, m_axis_tvalid, wp - rp);
    end
    repeat (3) tick();
    tests++;
    if (decouple_done !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL dec_mid_hold: got dd=%0b rd=%0b want 1 0", decouple_done, fifo_rd_en);
    end
    decouple = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      tick();
      if (m_axis_tvalid) got++;
    end
    tick();
    tests++;
    if (got != 3 || pkt_count !== CW'(2) || decouple_done !== 1'b0) begin
      fails++;
      $display("FAIL dec_mid_resume: got beats=%0d cnt=%0d dd=%0b want 3 2 0", got, pkt_count, decouple_done);
    end
  endtask

  task automatic test_decouple_idle();
    bit ok;
    do_reset();
    m_axis_tready = 1'b1;
    decouple = 1'b1;
    push_beat(1'b0, $urandom);
    push_beat(1'b1, $urandom);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL dec_idle_rd: got %0b want 0", fifo_rd_en);
    end
    tick();
    tests++;
    if (decouple_done !== 1'b1 || m_axis_tvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL dec_idle_done: got dd=%0b v=%0b rd=%0b want 1 0 0", decouple_done, m_axis_tvalid, fifo_rd_en);
    end
    repeat (3) tick();
    tests++;
    if (m_axis_tvalid !== 1'b0 || (wp - rp) !== 32'd2) begin
      fails++; $display("FAIL dec_idle_hold: got v=%0b fifo=%0d want 0 2", m_axis_tvalid, wp - rp);
    end
    decouple = 1'b0;
    tick();
    tests++;
    if (decouple_done !== 1'b0 || fifo_rd_en !== 1'b1) begin
      fails++; $display("FAIL dec_idle_resume: got dd=%0b rd=%0b want 0 1", decouple_done, fifo_rd_en);
    end
    drain(20, ok);
    tests++;
    if (!ok || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL dec_idle_drain: got ok=%0b cnt=%0d want 1 1", ok, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) push_beat(i == 5, $urandom);
    repeat (4) tick();
    tests++;
    if (m_axis_tvalid !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL rmid_pre: got v=%0b rd=%0b want 1 0", m_axis_tvalid, fifo_rd_en);
    end
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    tests++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== '0 || decouple_done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_post: got v=%0b cnt=%0d dd=%0b want 0 0 0", m_axis_tvalid, pkt_count, decouple_done);
    end
    // decouple blocks a read only at a packet boundary, so this shows the FSM is back in IDLE
    decouple = 1'b1;
    push_beat(1'b1, $urandom);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL rmid_idle: got rd=%0b want 0", fifo_rd_en);
    end
    tick();
    decouple = 1'b0;
    m_axis_tready = 1'b1;
    drain(20, ok);
    tests++;
    if (!ok || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL rmid_drain: got ok=%0b cnt=%0d want 1 1", ok, pkt_count);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int len;
    do_reset();
    m_axis_tready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) push_beat(b == len - 1, $urandom);
    end
    drain(60, ok);
    tests++;
    if (!ok || pkt_count !== CW'(1)) begin
      fails++; $display("FAIL wrap: got ok=%0b cnt=%0d want 1 1", ok, pkt_count);
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] pend [$];
    logic [EW-1:0] e;
    int npk, len;
    bit ok;
    do_reset();
    npk = $urandom_range(10, 14);
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) pend.push_back({b == len - 1, DW'($urandom)});
    end
    for (int c = 0; c < 600 && pend.size() > 0; c++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) decouple = ~decouple;
      if ($urandom_range(0, 2) != 0) begin
        e = pend.pop_front();
        push_beat(e[DW], e[DW-1:0]);
      end
      #1;
      if (decouple_done) begin
        tests++;
        if (m_axis_tvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin
          fails++;
          $display("FAIL rand_quiesce: got v=%0b rd=%0b want 0 0", m_axis_tvalid, fifo_rd_en);
        end
      end
      tick();
    end
    decouple = 1'b0;
    m_axis_tready = 1'b1;
    drain(300, ok);
    tests++;
    if (!ok || pend.size() != 0 || pkt_count !== CW'(npk)) begin
      fails++;
      $display("FAIL rand_final: got ok=%0b left=%0d cnt=%0d want 1 0 %0d", ok, pend.size(), pkt_count, CW'(npk));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_decouple_mid();
    test_decouple_idle();
    test_reset_mid();
    test_wrap();
    test_random();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
